mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 35 +++
 rtl/mux_scan_ctrl_hold_timer.sv | 40 ++++
 rtl/mux_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan sequencer.
// Select ordering and parity helpers live here so the FSM stays small.
package mux_scan_pkg;

    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        PAR  = 2'd2
    } state_t;

    // First select position of a scan for the chosen bit order.
    function automatic logic [SEL_W-1:0] first_sel(input bit msb_first);
        return msb_first ? SEL_TOP : '0;
    endfunction

    // Next select position; wraps naturally at the 2-bit width.
    function automatic logic [SEL_W-1:0] next_sel(
        input logic [SEL_W-1:0] s,
        input bit               msb_first
    );
        return msb_first ? (s - SEL_ONE) : (s + SEL_ONE);
    endfunction

    // Even parity of the latched word, taken directly from the data.
    function automatic logic parity4(input logic [NUM_IN-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_hold_timer.sv
// Hold counter: counts settle cycles per select value.
// Emits a combinational tick in the last hold cycle; clears on load.
module hold_timer
    import mux_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick,
    output logic err
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);
    assign err  = int'(cnt) > (HOLD_CYCLES - 1);

    // Count while enabled, wrap to zero after the last hold cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt >= LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Parallel-to-serial sequencer driving a 4:1 mux (w, S -> F).
// Optional trailing parity bit: define MUX_SCAN_CTRL_PARITY_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_data,
    output logic [NUM_IN-1:0] mux_w,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_f,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy
);

    localparam logic [2:0] LAST_BIT = 3'(NUM_IN - 1);
    localparam logic [2:0] PAR_BIT  = 3'(NUM_IN);
    localparam logic [2:0] BIT_ONE  = 3'd1;

    state_t     state;
    logic [2:0] bit_cnt;
    logic       accept;
    logic       timing;
    logic       tick;
    logic       hold_err;

    assign accept = (state == IDLE) && in_valid;
    assign timing = (state == SCAN) || (state == PAR);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (timing),
        .tick  (tick),
        .err   (hold_err)
    );

    // Scan FSM with registered handshake, mux drive and serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            mux_w     <= '0;
            mux_s     <= '0;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mux_w    <= in_data;
                        mux_s    <= first_sel(MSB_FIRST);
                        bit_cnt  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hold_err || (bit_cnt >= PAR_BIT)) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (tick) begin
                        ser_bit   <= mux_f;
                        ser_valid <= 1'b1;
                        mux_s     <= next_sel(mux_s, MSB_FIRST);
                        bit_cnt   <= bit_cnt + BIT_ONE;
                        if (bit_cnt == LAST_BIT) begin
`ifdef MUX_SCAN_CTRL_PARITY_EN
                            state    <= PAR;
`else
                            ser_last <= 1'b1;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
`endif
                        end
                    end
                end
`ifdef MUX_SCAN_CTRL_PARITY_EN
                PAR: begin
                    if (hold_err || (bit_cnt != PAR_BIT)) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (tick) begin
                        ser_bit   <= parity4(mux_w);
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
`endif
                default: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three parameterisations, bench-side 4:1 mux.
// Expected streams come from the bit-order/timing rules, not the FSM.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CTRL_PARITY_EN
    localparam int WL = 5;
`else
    localparam int WL = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       iv [3];
    logic [3:0] id [3];
    logic       ir [3];
    logic [3:0] mw [3];
    logic [1:0] ms [3];
    logic       mf [3];
    logic       sv [3];
    logic       sb [3];
    logic       sl [3];
    logic       bz [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Decoder-based 4:1 mux fed by each DUT, F looped back.
    for (genvar g = 0; g < 3; g++) begin : g_mux
        logic [3:0] dec;
        assign dec   = 4'b0001 << ms[g];
        assign mf[g] = |(dec & mw[g]);
    end

    mux_scan_ctrl #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u_h1_lsb (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .mux_w(mw[0]), .mux_s(ms[0]), .mux_f(mf[0]),
        .ser_valid(sv[0]), .ser_bit(sb[0]), .ser_last(sl[0]), .busy(bz[0])
    );

    mux_scan_ctrl #(.HOLD_CYCLES(1), .MSB_FIRST(1'b1)) u_h1_msb (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .mux_w(mw[1]), .mux_s(ms[1]), .mux_f(mf[1]),
        .ser_valid(sv[1]), .ser_bit(sb[1]), .ser_last(sl[1]), .busy(bz[1])
    );

    mux_scan_ctrl #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) u_h3_lsb (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .mux_w(mw[2]), .mux_s(ms[2]), .mux_f(mf[2]),
        .ser_valid(sv[2]), .ser_bit(sb[2]), .ser_last(sl[2]), .busy(bz[2])
    );

    function automatic int hc(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit msbf(input int i);
        return i == 1;
    endfunction

    function automatic logic [1:0] ref_sel(input int k, input bit msb);
        return msb ? 2'(3 - k) : 2'(k);
    endfunction

    function automatic logic ref_bit(input logic [3:0] d, input int k,
                                     input bit msb);
        if (k >= 4) return ^d;
        return d[ref_sel(k, msb)];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int i);
        chk("rst_in_ready", ir[i], 4'd1);
        chk("rst_mux_w", mw[i], 4'd0);
        chk("rst_mux_s", ms[i], 4'd0);
        chk("rst_ser_valid", sv[i], 4'd0);
        chk("rst_ser_bit", sb[i], 4'd0);
        chk("rst_ser_last", sl[i], 4'd0);
        chk("rst_busy", bz[i], 4'd0);
    endtask

    // Offer word d at the current negedge and follow its whole scan.
    // Ends at the negedge of the ser_last cycle; with chain set, nd is
    // left on the bus with in_valid high so it is taken in that cycle.
    task automatic scan_word(input int i, input logic [3:0] d,
                             input bit chain, input logic [3:0] nd);
        int h;
        int total;
        h     = hc(i);
        total = WL * h;
        id[i] = d;
        iv[i] = 1'b1;
        chk("accept_ready", ir[i], 4'd1);
        @(posedge clk);
        @(negedge clk);
        iv[i] = 1'b1;
        id[i] = chain ? nd : ~d;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clk);
            chk("mux_w", mw[i], d);
            chk("busy", bz[i], 4'(c < total));
            chk("in_ready", ir[i], 4'(c == total));
            chk("ser_valid", sv[i], 4'(c > 0 && c % h == 0));
            chk("ser_last", sl[i], 4'(c == total));
            if (c > 0 && c % h == 0)
                chk("ser_bit", sb[i], 4'(ref_bit(d, c / h - 1, msbf(i))));
            if (c / h < 4)
                chk("mux_s", ms[i], 4'(ref_sel(c / h, msbf(i))));
            if (c == total - 1 && !chain) iv[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ri;
        logic [3:0] rd;
        logic [3:0] rnd;
        bit         rchain;
        bit         chained;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            id[i] = 4'h0;
        end
        #2;
        for (int i = 0; i < 3; i++) chk_reset(i);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        scan_word(0, 4'b1011, 1'b0, 4'h0);
        scan_word(1, 4'b1011, 1'b0, 4'h0);
        scan_word(2, 4'b0110, 1'b0, 4'h0);
        scan_word(0, 4'hA, 1'b1, 4'h5);
        scan_word(0, 4'h5, 1'b0, 4'h0);
        scan_word(0, 4'b0111, 1'b0, 4'h0);
        scan_word(2, 4'b0111, 1'b0, 4'h0);

        // Reset in the middle of a scan of 4'hF after two bits.
        @(negedge clk);
        id[0] = 4'hF;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", bz[0], 4'd1);
        #1 reset = 1'b1;
        #1;
        chk_reset(0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_ser_last", sl[0], 4'd0);
            chk("post_rst_ser_valid", sv[0], 4'd0);
        end
        scan_word(0, 4'h3, 1'b0, 4'h0);

        // Random words on random instances, some back-to-back.
        chained = 1'b0;
        ri      = 0;
        rd      = 4'h0;
        for (int r = 0; r < 30; r++) begin
            if (!chained) begin
                ri = $urandom_range(0, 2);
                rd = 4'($urandom);
            end
            rchain = ($urandom_range(0, 1) == 1) && (r < 29);
            rnd    = 4'($urandom);
            scan_word(ri, rd, rchain, rnd);
            rd      = rnd;
            chained = rchain;
            if (!rchain && $urandom_range(0, 1) == 1) @(negedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
